risc16_fetch: RTL and testbench

Instruction fetch stage for the RISC-16 datapath. It holds the program counter and runs a request/acknowledge handshake with instruction memory. It latches the returned word and presents decoded instruction fields to the control decoder and datapath under a valid/ready handshake. When an instruction retires, it consumes the decoder's 2-bit PC-select to form the next PC.

---
 rtl/risc16_fetch_if.sv | 56 +++++
 rtl/risc16_fetch.sv | 180 ++++++++++++++++++
 tb/tb_risc16_fetch.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/risc16_fetch_if.sv
// -----------------------------------------------------------------------------
// risc16_fetch_if
//
// Purpose:
//    Groups the signals between the RISC-16 fetch stage and its surroundings.
//    This covers the instruction-memory request/ack bus, the decoded-instruction
//    valid/ready handshake, and the next-PC selection inputs from control and
//    the datapath.
//
// Modports:
//    master : the fetch stage (risc16_fetch). It drives the request, the fields
//             and the pc, and receives ack, ready and the next-PC selection.
//    slave  : the environment (memory, decoder, datapath, or a testbench).
//
// Signal summary:
//    imem_req/imem_addr/imem_ack/imem_rdata  instruction memory handshake
//    inst_valid/inst_ready                   issue handshake to decoder
//    op/rega/regb/regc/imm7/imm10            decoded fields of ir
//    pc/pc_plus1                             address of issued instruction, +1
//    mux_pc/branch_target/jalr_target        next-PC selection at retire
//    halted                                  fetch stopped on HALT
// -----------------------------------------------------------------------------
interface risc16_fetch_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [2:0]  op;
   logic [2:0]  rega;
   logic [2:0]  regb;
   logic [2:0]  regc;
   logic [15:0] imm7;
   logic [9:0]  imm10;
   logic [15:0] pc;
   logic [15:0] pc_plus1;
   logic [1:0]  mux_pc;
   logic [15:0] branch_target;
   logic [15:0] jalr_target;
   logic        halted;

   modport master (
      output imem_req, imem_addr, inst_valid, op, rega, regb, regc,
             imm7, imm10, pc, pc_plus1, halted,
      input  imem_ack, imem_rdata, inst_ready, mux_pc, branch_target,
             jalr_target
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, op, rega, regb, regc,
             imm7, imm10, pc, pc_plus1, halted,
      output imem_ack, imem_rdata, inst_ready, mux_pc, branch_target,
             jalr_target
   );
endinterface

// File: rtl/risc16_fetch.sv
// -----------------------------------------------------------------------------
// risc16_fetch
//
// Purpose:
//    Instruction fetch stage for the RISC-16 datapath. It holds the PC, fetches
//    one word from instruction memory with a request/ack handshake, and latches
//    that word into ir. It presents the decoded fields under a valid/ready
//    handshake. When the instruction retires, it forms the next PC from the
//    2-bit mux_pc select.
//
// Ports:
//    clk  : rising-edge clock
//    rst  : synchronous active-high reset
//    bus  : risc16_fetch_if.master (memory bus, issue handshake, fields,
//           pc/pc_plus1, next-PC select inputs, halted)
//
// Parameters:
//    RESET_PC : PC value loaded on reset (default 16'h0000)
//
// Configuration:
//    RISC16_HALT_EN : when defined, the word 111_000_000_xxxxxxx with a
//                     non-zero low field is treated as HALT. It is swallowed
//                     in FETCH, never issued, and the stage parks in HALT
//                     until reset. When undefined, the HALT state does not
//                     exist, halted is tied low, and the word issues as an
//                     ordinary JALR.
// -----------------------------------------------------------------------------
module risc16_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic           clk,
   input  logic           rst,
   risc16_fetch_if.master bus
);

`ifdef RISC16_HALT_EN
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_ISSUE = 2'd1,
      S_HALT  = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_ISSUE = 2'd1
   } state_t;
`endif

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;

   logic        req_c;
   logic        valid_c;
   logic [15:0] pc_inc;
   logic [15:0] pc_sel;
   logic [15:0] imm7_w;

   // ---------------------------------------------------------------------------
   // State, PC and instruction register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-PC selection; all arithmetic wraps at 16 bits
   // ---------------------------------------------------------------------------
   assign pc_inc = pc_q + 16'd1;

   always_comb begin
      pc_sel = pc_inc;
      unique case (bus.mux_pc)
         2'b01:   pc_sel = bus.branch_target;
         2'b10:   pc_sel = bus.jalr_target;
         default: pc_sel = pc_inc;
      endcase
   end

`ifdef RISC16_HALT_EN
   // HALT is the JALR encoding with both register fields zero and a non-zero
   // low field, so a genuine "JALR r0, r0" (low field zero) still issues.
   logic is_halt_word;
   assign is_halt_word = (bus.imem_rdata[15:13] == 3'b111) &&
                         (bus.imem_rdata[12:7]  == 6'd0)   &&
                         (bus.imem_rdata[6:0]   != 7'd0);
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      req_c   = 1'b0;
      valid_c = 1'b0;

      case (state_q)
         S_FETCH: begin
            req_c = 1'b1;
            if (bus.imem_ack) begin
`ifdef RISC16_HALT_EN
               if (is_halt_word) begin
                  state_d = S_HALT;
               end else begin
                  ir_d    = bus.imem_rdata;
                  state_d = S_ISSUE;
               end
`else
               ir_d    = bus.imem_rdata;
               state_d = S_ISSUE;
`endif
            end
         end

         S_ISSUE: begin
            valid_c = 1'b1;
            // mux_pc and the targets matter only in this handshake cycle.
            if (bus.inst_ready) begin
               pc_d    = pc_sel;
               state_d = S_FETCH;
            end
         end

`ifdef RISC16_HALT_EN
         S_HALT: begin
            state_d = S_HALT;
         end
`endif

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // The handshake outputs are forced low while rst is high, so the stage is
   // quiet even in the reset cycle itself, before the registers have reloaded.
   assign bus.imem_req   = req_c   & ~rst;
   assign bus.inst_valid = valid_c & ~rst;
   assign bus.imem_addr  = pc_q;
   assign bus.pc         = pc_q;
   assign bus.pc_plus1   = pc_inc;

`ifdef RISC16_HALT_EN
   assign bus.halted = (state_q == S_HALT) & ~rst;
`else
   assign bus.halted = 1'b0;
`endif

   // Decoded fields are combinational from ir.
   assign bus.op    = ir_q[15:13];
   assign bus.rega  = ir_q[12:10];
   assign bus.regb  = ir_q[9:7];
   assign bus.regc  = ir_q[2:0];
   assign bus.imm10 = ir_q[9:0];

   // Sign-extend the 7-bit immediate by replicating ir[6] into the upper bits.
   assign imm7_w[6:0] = ir_q[6:0];
   genvar gi;
   generate
      for (gi = 7; gi < 16; gi++) begin : g_sext
         assign imm7_w[gi] = ir_q[6];
      end
   endgenerate
   assign bus.imm7 = imm7_w;

endmodule

// File: tb/tb_risc16_fetch.sv
module tb_risc16_fetch;

   logic clk;
   logic rst;

   risc16_fetch_if bus_if ();

   risc16_fetch #(.RESET_PC(16'h0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] pc;        // expected fetch address
      int          ack_dly;   // cycles before imem_ack
      int          rdy_dly;   // cycles before inst_ready
      logic [15:0] rdata;
      logic [1:0]  mux;
      logic [15:0] btgt;
      logic [15:0] jtgt;
      logic [2:0]  op;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [2:0]  rc;
      logic [15:0] imm7;
      logic [9:0]  imm10;
      logic [15:0] pcp1;
      logic [15:0] next_pc;
   } vec_t;

   vec_t vecs [6];

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_fields(input vec_t v, input string tag);
      chk({tag, " op"},       {13'd0, bus_if.op},   {13'd0, v.op});
      chk({tag, " rega"},     {13'd0, bus_if.rega}, {13'd0, v.ra});
      chk({tag, " regb"},     {13'd0, bus_if.regb}, {13'd0, v.rb});
      chk({tag, " regc"},     {13'd0, bus_if.regc}, {13'd0, v.rc});
      chk({tag, " imm7"},     bus_if.imm7,          v.imm7);
      chk({tag, " imm10"},    {6'd0, bus_if.imm10}, {6'd0, v.imm10});
      chk({tag, " pc"},       bus_if.pc,            v.pc);
      chk({tag, " pc_plus1"}, bus_if.pc_plus1,      v.pcp1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //       pc       ack rdy rdata     mux    btgt      jtgt      op     ra    rb    rc    imm7      imm10    pcp1      next
      vecs[0] = '{16'h0000, 0, 0, 16'h2481, 2'b00, 16'h0000, 16'h0000, 3'd1, 3'd1, 3'd1, 3'd1, 16'h0001, 10'h081, 16'h0001, 16'h0001};
      vecs[1] = '{16'h0001, 0, 0, 16'h0000, 2'b01, 16'h0010, 16'h0000, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 10'h000, 16'h0002, 16'h0010};
      vecs[2] = '{16'h0010, 0, 0, 16'hC07F, 2'b01, 16'h000A, 16'h0000, 3'd6, 3'd0, 3'd0, 3'd7, 16'hFFFF, 10'h07F, 16'h0011, 16'h000A};
      vecs[3] = '{16'h000A, 1, 1, 16'hE480, 2'b10, 16'h0000, 16'hFFFF, 3'd7, 3'd1, 3'd1, 3'd0, 16'h0000, 10'h080, 16'h000B, 16'hFFFF};
      vecs[4] = '{16'hFFFF, 0, 2, 16'h5F3C, 2'b00, 16'h1234, 16'h5678, 3'd2, 3'd7, 3'd6, 3'd4, 16'h003C, 10'h33C, 16'h0000, 16'h0000};
      vecs[5] = '{16'h0000, 3, 4, 16'h8040, 2'b11, 16'h1234, 16'h5678, 3'd4, 3'd0, 3'd0, 3'd0, 16'hFFC0, 10'h040, 16'h0001, 16'h0001};

      rst                  = 1'b1;
      bus_if.imem_ack      = 1'b0;
      bus_if.imem_rdata    = 16'h0000;
      bus_if.inst_ready    = 1'b0;
      bus_if.mux_pc        = 2'b00;
      bus_if.branch_target = 16'h0000;
      bus_if.jalr_target   = 16'h0000;

      // Reset state
      step();
      chk("rst imem_req",   {15'd0, bus_if.imem_req},   16'd0);
      chk("rst inst_valid", {15'd0, bus_if.inst_valid}, 16'd0);
      chk("rst halted",     {15'd0, bus_if.halted},     16'd0);
      step();
      rst = 1'b0;
      #1;
      chk("post-rst imem_req",  {15'd0, bus_if.imem_req}, 16'd1);
      chk("post-rst imem_addr", bus_if.imem_addr,         16'h0000);

      // Table-driven fetch/issue/retire loop
      for (int i = 0; i < 6; i++) begin
         vec_t v;
         v = vecs[i];
         chk($sformatf("v%0d imem_req", i), {15'd0, bus_if.imem_req}, 16'd1);
         chk($sformatf("v%0d imem_addr", i), bus_if.imem_addr, v.pc);
         for (int d = 0; d < v.ack_dly; d++) begin
            bus_if.mux_pc = 2'($urandom_range(0, 3));
            step();
            chk($sformatf("v%0d wait-ack req", i),  {15'd0, bus_if.imem_req}, 16'd1);
            chk($sformatf("v%0d wait-ack addr", i), bus_if.imem_addr, v.pc);
            chk($sformatf("v%0d wait-ack pc", i),   bus_if.pc,        v.pc);
         end
         bus_if.imem_ack   = 1'b1;
         bus_if.imem_rdata = v.rdata;
         step();
         bus_if.imem_ack   = 1'b0;
         bus_if.imem_rdata = 16'hDEAD;
         chk($sformatf("v%0d inst_valid", i), {15'd0, bus_if.inst_valid}, 16'd1);
         chk($sformatf("v%0d req low", i),    {15'd0, bus_if.imem_req},   16'd0);
         chk_fields(v, $sformatf("v%0d", i));
         for (int d = 0; d < v.rdy_dly; d++) begin
            // Stray ack and changing mux_pc while not ready must be ignored.
            bus_if.imem_ack      = 1'b1;
            bus_if.imem_rdata    = 16'(16'hA5A5 + d);
            bus_if.mux_pc        = 2'(d);
            bus_if.branch_target = 16'h7777;
            bus_if.jalr_target   = 16'h8888;
            step();
            chk($sformatf("v%0d wait-rdy valid", i), {15'd0, bus_if.inst_valid}, 16'd1);
            chk_fields(v, $sformatf("v%0d hold%0d", i, d));
         end
         bus_if.imem_ack      = 1'b0;
         bus_if.inst_ready    = 1'b1;
         bus_if.mux_pc        = v.mux;
         bus_if.branch_target = v.btgt;
         bus_if.jalr_target   = v.jtgt;
         step();
         bus_if.inst_ready    = 1'b0;
         bus_if.mux_pc        = 2'b01;
         bus_if.branch_target = 16'hBEEF;
         bus_if.jalr_target   = 16'hCAFE;
         chk($sformatf("v%0d retire valid", i), {15'd0, bus_if.inst_valid}, 16'd0);
         chk($sformatf("v%0d next req", i),     {15'd0, bus_if.imem_req},   16'd1);
         chk($sformatf("v%0d next addr", i),    bus_if.imem_addr,           v.next_pc);
      end

      // Reset mid-ISSUE with a simultaneous ready handshake
      bus_if.imem_ack   = 1'b1;
      bus_if.imem_rdata = 16'h2481;
      step();
      bus_if.imem_ack   = 1'b0;
      chk("midrst pre valid", {15'd0, bus_if.inst_valid}, 16'd1);
      chk("midrst pre pc",    bus_if.pc,                  16'h0001);
      rst                  = 1'b1;
      bus_if.inst_ready    = 1'b1;
      bus_if.mux_pc        = 2'b01;
      bus_if.branch_target = 16'h0100;
      step();
      bus_if.inst_ready = 1'b0;
      chk("midrst valid", {15'd0, bus_if.inst_valid}, 16'd0);
      chk("midrst req",   {15'd0, bus_if.imem_req},   16'd0);
      chk("midrst pc",    bus_if.pc,                  16'h0000);
      rst = 1'b0;
      #1;
      chk("midrst rel req",  {15'd0, bus_if.imem_req}, 16'd1);
      chk("midrst rel addr", bus_if.imem_addr,         16'h0000);

      // HALT word
      bus_if.imem_ack   = 1'b1;
      bus_if.imem_rdata = 16'hE001;
      step();
      bus_if.imem_ack   = 1'b0;
`ifdef RISC16_HALT_EN
      chk("halt halted", {15'd0, bus_if.halted},     16'd1);
      chk("halt valid",  {15'd0, bus_if.inst_valid}, 16'd0);
      chk("halt req",    {15'd0, bus_if.imem_req},   16'd0);
      for (int d = 0; d < 3; d++) begin
         bus_if.imem_ack   = 1'b1;
         bus_if.inst_ready = 1'b1;
         step();
         chk("halt hold halted", {15'd0, bus_if.halted},     16'd1);
         chk("halt hold req",    {15'd0, bus_if.imem_req},   16'd0);
         chk("halt hold valid",  {15'd0, bus_if.inst_valid}, 16'd0);
      end
      bus_if.imem_ack   = 1'b0;
      bus_if.inst_ready = 1'b0;
      rst = 1'b1;
      step();
      chk("halt rst halted", {15'd0, bus_if.halted}, 16'd0);
      rst = 1'b0;
      #1;
      chk("halt rst req", {15'd0, bus_if.imem_req}, 16'd1);
`else
      chk("jalr valid",  {15'd0, bus_if.inst_valid}, 16'd1);
      chk("jalr op",     {13'd0, bus_if.op},         16'd7);
      chk("jalr regc",   {13'd0, bus_if.regc},       16'd1);
      chk("jalr halted", {15'd0, bus_if.halted},     16'd0);
      bus_if.inst_ready = 1'b1;
      bus_if.mux_pc     = 2'b00;
      step();
      bus_if.inst_ready = 1'b0;
      chk("jalr next addr", bus_if.imem_addr,        16'h0001);
      chk("jalr halted2",   {15'd0, bus_if.halted}, 16'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
